// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller, the NCO itself and benches.
package nco_ctrl_pkg;

  localparam int unsigned ACC_INT_WIDTH  = 8;
  localparam int unsigned ACC_FRAC_WIDTH = 24;
  localparam int unsigned ACC_WIDTH      = ACC_INT_WIDTH + ACC_FRAC_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DWELL,
    DONE,
    PARK
  } sweep_state_t;

  // Phase increment for a tone of freq Hz at sample clock fclk Hz (bench use).
  function automatic logic [ACC_WIDTH-1:0] hz_to_step(input longint unsigned freq,
                                                      input longint unsigned fclk);
    longint unsigned scaled;
    scaled = (freq << ACC_WIDTH) / fclk;
    return ACC_WIDTH'(scaled);
  endfunction

endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// Down-counter that times the dwell of one sweep point.
module dwell_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over clear; otherwise count down to zero and stop there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (clear) begin
      count_d = '0;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Last cycle of a loaded dwell period.
  assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the NCO step AXI-stream slave.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned ACC_INT_WIDTH  = nco_ctrl_pkg::ACC_INT_WIDTH,
  parameter int unsigned ACC_FRAC_WIDTH = nco_ctrl_pkg::ACC_FRAC_WIDTH,
  parameter int unsigned ACC_WIDTH      = ACC_INT_WIDTH + ACC_FRAC_WIDTH,
  parameter int unsigned DWELL_WIDTH    = 24,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [ACC_WIDTH-1:0]   cfg_start_step,
  input  logic [ACC_WIDTH-1:0]   cfg_stop_step,
  input  logic [ACC_WIDTH-1:0]   cfg_delta_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  input  logic                   start,
  input  logic                   abort,
  output logic [ACC_WIDTH-1:0]   m_axis_step_tdata,
  output logic                   m_axis_step_tvalid,
  input  logic                   m_axis_step_tready,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   point_count
);

  sweep_state_t state_q, state_d;

  logic [ACC_WIDTH-1:0]   start_q, start_d;
  logic [ACC_WIDTH-1:0]   stop_q, stop_d;
  logic [ACC_WIDTH-1:0]   delta_q, delta_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic                   loop_q, loop_d;
  logic                   single_q, single_d;
  logic [ACC_WIDTH-1:0]   cur_q, cur_d;
  logic [ACC_WIDTH-1:0]   tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   pc_q, pc_d;

  logic                   hs;
  logic [ACC_WIDTH:0]     next_sum;
  logic                   next_ok;
  logic                   tmr_load;
  logic                   tmr_clear;
  logic                   tmr_expire;

  dwell_timer #(
    .WIDTH (DWELL_WIDTH)
  ) u_dwell_timer (
    .clk      (aclk),
    .rst_n    (arst_n),
    .load     (tmr_load),
    .clear    (tmr_clear),
    .load_val (dwell_q),
    .expire   (tmr_expire)
  );

  assign hs       = tvalid_q && m_axis_step_tready;
  assign next_sum = {1'b0, cur_q} + {1'b0, delta_q};
  assign next_ok  = !next_sum[ACC_WIDTH] && (next_sum[ACC_WIDTH-1:0] <= stop_q);

  // Next-state, shadow latch and registered-output computation.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    stop_d    = stop_q;
    delta_d   = delta_q;
    dwell_d   = dwell_q;
    loop_d    = loop_q;
    single_d  = single_q;
    cur_d     = cur_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    pc_d      = pc_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          start_d  = cfg_start_step;
          stop_d   = cfg_stop_step;
          delta_d  = cfg_delta_step;
          dwell_d  = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
          loop_d   = cfg_loop;
          single_d = (cfg_delta_step == '0) || (cfg_start_step > cfg_stop_step);
          cur_d    = cfg_start_step;
          pc_d     = '0;
          tdata_d  = cfg_start_step;
          tvalid_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          pc_d     = (pc_q == '1) ? pc_q : pc_q + CNT_WIDTH'(1);
          tmr_load = 1'b1;
          tvalid_d = 1'b0;
          state_d  = DWELL;
        end
      end
      DWELL: begin
        if (tmr_expire) begin
          if (single_q) begin
            state_d = DONE;
          end else if (next_ok) begin
            cur_d    = next_sum[ACC_WIDTH-1:0];
            tdata_d  = next_sum[ACC_WIDTH-1:0];
            tvalid_d = 1'b1;
            state_d  = ISSUE;
          end else if (loop_q) begin
            cur_d    = start_q;
            tdata_d  = start_q;
            tvalid_d = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      PARK: begin
        if (hs) begin
          tvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides the transition chosen above but keeps the point count
    // of a step accepted on the same edge, since the NCO did take it.
    if (abort && (state_q != IDLE) && (state_q != PARK)) begin
      tdata_d   = '0;
      tvalid_d  = 1'b1;
      tmr_load  = 1'b0;
      tmr_clear = 1'b1;
      state_d   = PARK;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, shadow and output registers.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      start_q  <= '0;
      stop_q   <= '0;
      delta_q  <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      single_q <= 1'b0;
      cur_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      delta_q  <= delta_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
      single_q <= single_d;
      cur_q    <= cur_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pc_q     <= pc_d;
    end
  end

  assign m_axis_step_tdata  = tdata_q;
  assign m_axis_step_tvalid = tvalid_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign point_count        = pc_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl.
module tb_nco_sweep_ctrl;
  import nco_ctrl_pkg::*;

  localparam int unsigned AW = nco_ctrl_pkg::ACC_WIDTH;

  typedef struct {
    logic [AW-1:0] data;
    int            gap;
  } exp_t;

  logic          aclk;
  logic          arst_n;
  logic [AW-1:0] cfg_start_step, cfg_stop_step, cfg_delta_step;
  logic [23:0]   cfg_dwell;
  logic          cfg_loop;
  logic          start, abort, tready;
  logic [AW-1:0] tdata;
  logic          tvalid, busy, done;
  logic [15:0]   point_count;

  logic          start2, abort2;
  logic [AW-1:0] tdata2;
  logic          tvalid2, busy2, done2;
  logic [7:0]    pc2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs = 0;
  int done_cnt = 0;
  exp_t q[$];

  nco_sweep_ctrl dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_start_step     (cfg_start_step),
    .cfg_stop_step      (cfg_stop_step),
    .cfg_delta_step     (cfg_delta_step),
    .cfg_dwell          (cfg_dwell),
    .cfg_loop           (cfg_loop),
    .start              (start),
    .abort              (abort),
    .m_axis_step_tdata  (tdata),
    .m_axis_step_tvalid (tvalid),
    .m_axis_step_tready (tready),
    .busy               (busy),
    .done               (done),
    .point_count        (point_count)
  );

  nco_sweep_ctrl #(
    .CNT_WIDTH (8)
  ) dut_sat (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_start_step     (cfg_start_step),
    .cfg_stop_step      (cfg_stop_step),
    .cfg_delta_step     (cfg_delta_step),
    .cfg_dwell          (cfg_dwell),
    .cfg_loop           (cfg_loop),
    .start              (start2),
    .abort              (abort2),
    .m_axis_step_tdata  (tdata2),
    .m_axis_step_tvalid (tvalid2),
    .m_axis_step_tready (tready),
    .busy               (busy2),
    .done               (done2),
    .point_count        (pc2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Handshake monitor: inputs only change just after posedge, so the negedge
  // view predicts what the next posedge accepts.
  always @(negedge aclk) begin
    if (arst_n && done) done_cnt++;
    if (arst_n && tvalid && tready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step got %0h expected none", tdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (tdata !== e.data) begin
          errors++;
          $display("FAIL step_data got %0h expected %0h", tdata, e.data);
        end
        if (e.gap != 0) begin
          checks++;
          if ((cyc + 1 - last_hs) != e.gap) begin
            errors++;
            $display("FAIL step_gap got %0d expected %0d (data %0h)",
                     cyc + 1 - last_hs, e.gap, e.data);
          end
        end
      end
      last_hs = cyc + 1;
      hs_cnt++;
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    q.push_back(e);
  endtask

  task automatic set_cfg(input logic [AW-1:0] s, input logic [AW-1:0] p,
                         input logic [AW-1:0] d, input logic [23:0] dw, input logic lp);
    cfg_start_step = s;
    cfg_stop_step  = p;
    cfg_delta_step = d;
    cfg_dwell      = dw;
    cfg_loop       = lp;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    int n = 0;
    while (busy && n < maxc) begin
      step();
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    step();
    checks++;
    if (tdata !== '0 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_stream got tdata %0h tvalid %b expected 0 0", tdata, tvalid);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || point_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_status got busy %b done %b pc %0d expected 0 0 0",
               busy, done, point_count);
    end
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    set_cfg(1000, 1300, 100, 3, 1'b0);
    push(1000, 0); push(1100, 4); push(1200, 4); push(1300, 4);
    done_cnt = 0;
    pulse_start();
    checks++;
    if (tvalid !== 1'b1 || tdata !== 1000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first got tvalid %b tdata %0d busy %b expected 1 1000 1",
               tvalid, tdata, busy);
    end
    wait_idle(100, ok);
    checks++;
    if (!ok || q.size() != 0) begin
      errors++;
      $display("FAIL basic_complete got idle %b pending %0d expected 1 0", ok, q.size());
    end
    checks++;
    if (done_cnt != 1 || point_count !== 16'd4 || tdata !== 1300) begin
      errors++;
      $display("FAIL basic_end got done %0d pc %0d tdata %0d expected 1 4 1300",
               done_cnt, point_count, tdata);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n = 0;
    set_cfg(1000, 1300, 100, 3, 1'b0);
    push(1000, 0); push(1100, 0); push(1200, 4); push(1300, 4);
    pulse_start();
    while (!(tvalid && tdata == 1100) && n < 50) begin
      step();
      n++;
    end
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (tvalid !== 1'b1 || tdata !== 1100) begin
        errors++;
        $display("FAIL bp_hold got tvalid %b tdata %0d expected 1 1100", tvalid, tdata);
      end
    end
    tready = 1'b1;
    wait_idle(100, ok);
    checks++;
    if (!ok || q.size() != 0 || point_count !== 16'd4) begin
      errors++;
      $display("FAIL bp_complete got idle %b pending %0d pc %0d expected 1 0 4",
               ok, q.size(), point_count);
    end
  endtask

  task automatic test_loop_abort();
    int n = 0;
    int base;
    set_cfg(1000, 1200, 100, 2, 1'b1);
    push(1000, 0); push(1100, 3); push(1200, 3); push(1000, 3); push(1100, 3);
    push(0, 0);
    done_cnt = 0;
    base = hs_cnt;
    pulse_start();
    while (hs_cnt < base + 5 && n < 100) begin
      step();
      n++;
    end
    tready = 1'b0;
    abort  = 1'b1;
    step();
    abort  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL park_hold got tvalid %b tdata %0h busy %b expected 1 0 1",
                 tvalid, tdata, busy);
      end
      step();
    end
    tready = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || tvalid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL park_exit got busy %b tvalid %b pending %0d expected 0 0 0",
               busy, tvalid, q.size());
    end
    checks++;
    if (done_cnt != 0 || point_count !== 16'd5) begin
      errors++;
      $display("FAIL abort_status got done %0d pc %0d expected 0 5", done_cnt, point_count);
    end
  endtask

  task automatic test_single(input logic [AW-1:0] s, input logic [AW-1:0] p,
                             input logic [AW-1:0] d, input logic lp, input string name);
    bit ok;
    set_cfg(s, p, d, 1, lp);
    push(s, 0);
    done_cnt = 0;
    pulse_start();
    wait_idle(50, ok);
    checks++;
    if (!ok || q.size() != 0 || done_cnt != 1 || point_count !== 16'd1) begin
      errors++;
      $display("FAIL %s got idle %b pending %0d done %0d pc %0d expected 1 0 1 1",
               name, ok, q.size(), done_cnt, point_count);
    end
  endtask

  task automatic test_dwell_zero();
    bit ok;
    set_cfg(10, 30, 10, 0, 1'b0);
    push(10, 0); push(20, 2); push(30, 2);
    pulse_start();
    wait_idle(50, ok);
    checks++;
    if (!ok || q.size() != 0 || point_count !== 16'd3) begin
      errors++;
      $display("FAIL dwell_zero got idle %b pending %0d pc %0d expected 1 0 3",
               ok, q.size(), point_count);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    set_cfg(1000, 1300, 100, 3, 1'b0);
    push(1000, 0); push(1100, 4); push(1200, 4); push(1300, 4);
    tready = 1'b0;
    pulse_start();
    set_cfg(7777, 9000, 5, 1, 1'b1);
    pulse_start();
    tready = 1'b1;
    wait_idle(100, ok);
    checks++;
    if (!ok || q.size() != 0 || point_count !== 16'd4 || tdata !== 1300) begin
      errors++;
      $display("FAIL start_busy got idle %b pending %0d pc %0d tdata %0d expected 1 0 4 1300",
               ok, q.size(), point_count, tdata);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int base;
    set_cfg(1000, 1300, 100, 6, 1'b1);
    push(1000, 0);
    base = hs_cnt;
    pulse_start();
    while (hs_cnt < base + 1 && n < 20) begin
      step();
      n++;
    end
    step();
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (tdata !== '0 || tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        point_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid got tdata %0h tvalid %b busy %b done %b pc %0d expected 0",
               tdata, tvalid, busy, done, point_count);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_first got pending %0d expected 0", q.size());
    end
    step();
    arst_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    int n = 0;
    set_cfg(42, 42, 1, 0, 1'b1);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 620; i++) step();
    checks++;
    if (pc2 !== 8'hFF || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL pc_saturate got pc %0d busy %b expected 255 1", pc2, busy2);
    end
    abort2 = 1'b1;
    step();
    abort2 = 1'b0;
    while (busy2 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (busy2 !== 1'b0 || pc2 !== 8'hFF) begin
      errors++;
      $display("FAIL sat_abort got busy %b pc %0d expected 0 255", busy2, pc2);
    end
  endtask

  initial begin
    arst_n = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    start2 = 1'b0;
    abort2 = 1'b0;
    tready = 1'b1;
    set_cfg('0, '0, '0, '0, 1'b0);
    test_reset();
    test_basic();
    test_backpressure();
    test_loop_abort();
    test_single(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 1'b0, "carry_end");
    test_single(500, 900, 0, 1'b1, "delta_zero");
    test_single(2000, 1000, 100, 1'b0, "start_gt_stop");
    test_dwell_zero();
    test_start_ignored();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
